dff_1: RTL and testbench



---
 rtl/dff_1_if.sv | 26 ++
 rtl/dff_1.sv | 52 +++++
 tb/tb_dff_1.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dff_1_if.sv
// dff_1_if -- bundles the data path of a dff_1 register (d in, q out).
//
// Parameters:
//   WIDTH  data width in bits (1..64)
//
// Signals:
//   d  data presented to the register
//   q  registered data returned by the register
//
// Modports:
//   master  drives d and observes q (the producer/consumer side)
//   slave   consumes d and drives q (the register side)
//
// dff_1 keeps plain d/q/clock/reset ports so that positional instantiation
// dff_1(d, q, clock, reset) keeps working. A bench or parent block can
// still carry the data path as one bundle by hooking bus.d and bus.q onto
// those ports.
interface dff_1_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input q);
  modport slave  (input d, output q);
endinterface

// File: rtl/dff_1.sv
// dff_1 -- parameterisable positive-edge D flip-flop / delay line with
// synchronous active-high reset. It is the basic storage primitive of the
// 8-bit datapath.
//
// Parameters:
//   WIDTH        data width of d and q (1..64)
//   STAGES       number of cascaded register stages (1..16); latency = STAGES
//   RESET_VALUE  value loaded into every stage on reset; truncated to WIDTH
//
// Ports (declaration order is d, q, clock, reset):
//   d      in   WIDTH  data input, sampled on the rising edge of clock
//   q      out  WIDTH  output of the last stage register (no path from d)
//   clock  in   1      system clock, rising edge only
//   reset  in   1      synchronous active-high reset, priority over d
//
// Build option:
//   DFF_1_INIT_EN  when defined, every stage powers up holding RESET_VALUE,
//                  so q is valid before the first edge. When not defined,
//                  the stages have no initial value.
module dff_1 #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned STAGES      = 1,
  parameter logic [63:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             clock,
  input  logic             reset
);

  localparam logic [WIDTH-1:0] RstVal = RESET_VALUE[WIDTH-1:0];

  // r_stage[0] captures d, and r_stage[STAGES-1] drives q.
`ifdef DFF_1_INIT_EN
  logic [STAGES-1:0][WIDTH-1:0] r_stage = {STAGES{RstVal}};
`else
  logic [STAGES-1:0][WIDTH-1:0] r_stage;
`endif

  // A ternary is used in place of if/else. An X on reset then merges the
  // two sources, and q goes X where they differ. An if/else would quietly
  // take the non-reset branch.
  always_ff @(posedge clock) begin
    r_stage[0] <= reset ? RstVal : d;
    for (int i = 1; i < STAGES; i++) begin
      r_stage[i] <= reset ? RstVal : r_stage[i-1];
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: tb/tb_dff_1.sv
// tb_dff_1 -- self-checking bench for dff_1.
// DUT A: defaults (WIDTH=1, STAGES=1, RESET_VALUE=0).
// DUT B: WIDTH=8, STAGES=3, RESET_VALUE=8'h3C.
// The reference model keeps a history of the (d, reset) pair seen at every
// rising edge. After edge n, q is RESET_VALUE when any of the last STAGES
// edges had reset high. Otherwise q is the d sampled STAGES-1 edges earlier.
`timescale 1ns/100ps
module tb_dff_1;

  logic clock = 1'b0;
  logic rst_a;
  logic rst_b;

  dff_1_if #(.WIDTH(1)) bus_a ();
  dff_1_if #(.WIDTH(8)) bus_b ();

  always #1 clock = ~clock;

  dff_1 u_dut_a (
    .d     (bus_a.d),
    .q     (bus_a.q),
    .clock (clock),
    .reset (rst_a)
  );

  dff_1 #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (64'h3C)
  ) u_dut_b (
    .d     (bus_b.d),
    .q     (bus_b.q),
    .clock (clock),
    .reset (rst_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] hd_a[$];
  bit         hr_a[$];
  logic [7:0] hd_b[$];
  bit         hr_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {known, value} for the q expected right after the latest edge.
  function automatic logic [8:0] predict(input bit which, input int n, input logic [7:0] rv);
    int sz;
    sz = which ? hr_b.size() : hr_a.size();
    for (int k = 0; k < n; k++) begin
      if (k >= sz) begin
`ifdef DFF_1_INIT_EN
        return {1'b1, rv};
`else
        return 9'h000;
`endif
      end
      if (which ? hr_b[sz-1-k] : hr_a[sz-1-k]) return {1'b1, rv};
    end
    return {1'b1, (which ? hd_b[sz-n] : hd_a[sz-n])};
  endfunction

  // Wait for a rising edge, record its inputs, then compare both DUTs with
  // the model half a cycle later.
  task automatic tick();
    logic [8:0] pa;
    logic [8:0] pb;
    @(posedge clock);
    hd_a.push_back({7'b0, bus_a.d});
    hr_a.push_back(rst_a);
    hd_b.push_back(bus_b.d);
    hr_b.push_back(rst_b);
    #0.5;
    pa = predict(1'b0, 1, 8'h00);
    pb = predict(1'b1, 3, 8'h3C);
    if (pa[8]) chk("model_a", {63'b0, bus_a.q}, {56'b0, pa[7:0]});
    if (pb[8]) chk("model_b", {56'b0, bus_b.q}, {56'b0, pb[7:0]});
  endtask

  initial begin
    logic       hold_a;
    logic [7:0] hold_b;

    rst_a   = 1'b1;
    rst_b   = 1'b1;
    bus_a.d = 1'b1;
    bus_b.d = 8'hFF;
    #0.1;
`ifdef DFF_1_INIT_EN
    chk("init_a", {63'b0, bus_a.q}, 64'h0);
    chk("init_b", {56'b0, bus_b.q}, 64'h3C);
`endif

    // First edge at t=1 with reset high
    tick();
    chk("rst_q0_a", {63'b0, bus_a.q}, 64'h0);
    chk("rst_q_b", {56'b0, bus_b.q}, 64'h3C);

    // Capture d=1 at t=3
    rst_a   = 1'b0;
    bus_a.d = 1'b1;
    tick();
    chk("cap_d1", {63'b0, bus_a.q}, 64'h1);

    // Reset has priority over d and keeps q low
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.d = 1'($urandom_range(1));
      tick();
      chk("rst_prio", {63'b0, bus_a.q}, 64'h0);
    end

    // Toggle inputs between edges; q may only change at rising edges
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rst_a   = 1'b0;
      bus_a.d = 1'($urandom_range(1));
      bus_b.d = 8'($urandom);
      tick();
      hold_a = bus_a.q;
      hold_b = bus_b.q;
      rst_a   = ~rst_a;
      rst_b   = ~rst_b;
      bus_a.d = ~bus_a.d;
      bus_b.d = ~bus_b.d;
      #0.3;
      chk("hold_pre_a", {63'b0, bus_a.q}, {63'b0, hold_a});
      chk("hold_pre_b", {56'b0, bus_b.q}, {56'b0, hold_b});
      rst_a   = 1'($urandom_range(1));
      rst_b   = 1'b0;
      bus_a.d = 1'($urandom_range(1));
      #0.4;
      chk("hold_post_a", {63'b0, bus_a.q}, {63'b0, hold_a});
      chk("hold_post_b", {56'b0, bus_b.q}, {56'b0, hold_b});
    end

    // A5 through the 3-stage line
    rst_b = 1'b1;
    tick();
    rst_b   = 1'b0;
    bus_b.d = 8'hA5;
    tick();
    chk("a5_e0", {56'b0, bus_b.q}, 64'h3C);
    bus_b.d = 8'h00;
    tick();
    chk("a5_e1", {56'b0, bus_b.q}, 64'h3C);
    tick();
    chk("a5_e2", {56'b0, bus_b.q}, 64'hA5);
    tick();
    chk("a5_e3", {56'b0, bus_b.q}, 64'h00);

    // A5 in transit is flushed by reset and never reaches q
    bus_b.d = 8'hA5;
    tick();
    rst_b   = 1'b1;
    bus_b.d = 8'h00;
    tick();
    chk("flush_rst", {56'b0, bus_b.q}, 64'h3C);
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_a5", {63'b0, (bus_b.q == 8'hA5)}, 64'h0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_a   = ($urandom_range(7) == 0);
      rst_b   = ($urandom_range(9) == 0);
      bus_a.d = 1'($urandom_range(1));
      bus_b.d = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
